// File: rtl/note_capture_encoder.sv
// Captures an asynchronous one-hot note bus, debounces it and encodes each stable
// segment as a (note, rest, multi, duration) event queued in a fall-through FIFO.
module note_capture_encoder #(
  parameter int NUM_NOTES       = 8,
  parameter int IDX_W           = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DUR_W           = 8,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_NOTES-1:0]          note_in,
  input  logic                          clear_ovf,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [IDX_W-1:0]              evt_note,
  output logic                          evt_rest,
  output logic                          evt_multi,
  output logic [DUR_W-1:0]              evt_dur,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int EVT_W = IDX_W + 2 + DUR_W;
  localparam logic [DEB_W-1:0] DEB_TARGET = DEB_W'(DEBOUNCE_CYCLES);
  localparam logic [DEB_W-1:0] DEB_ONE    = DEB_W'(1);
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [DUR_W-1:0] DUR_MAX    = '1;

  logic [NUM_NOTES-1:0] sync1_reg, sync_reg;
  logic [NUM_NOTES-1:0] cand_reg, cand_next;
  logic [NUM_NOTES-1:0] stable_reg, stable_next;
  logic [DEB_W-1:0]     deb_cnt_reg, deb_cnt_next, deb_inc;
  logic                 stable_upd;

  logic [IDX_W-1:0]     cls_note;
  logic                 cls_rest, cls_multi;
  logic [DUR_W-1:0]     dur_reg, dur_inc;
  logic                 push_valid_reg;
  logic [EVT_W-1:0]     push_data_reg;

  logic [EVT_W-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]     count_reg, count_next;
  logic [EVT_W-1:0]     head_reg, head_next;
  logic                 overflow_reg;
  logic                 pop, push_ok, drop;

  // A return to the stable value always wins, so a glitch leaves no trace.
  always_comb begin
    cand_next    = cand_reg;
    stable_next  = stable_reg;
    deb_cnt_next = deb_cnt_reg;
    stable_upd   = 1'b0;
    deb_inc      = deb_cnt_reg + DEB_ONE;
    if (sync_reg == stable_reg) begin
      cand_next    = sync_reg;
      deb_cnt_next = '0;
    end else if (sync_reg != cand_reg) begin
      cand_next = sync_reg;
      if (DEB_ONE == DEB_TARGET) begin
        stable_next  = sync_reg;
        deb_cnt_next = '0;
        stable_upd   = 1'b1;
      end else begin
        deb_cnt_next = DEB_ONE;
      end
    end else if (deb_inc == DEB_TARGET) begin
      stable_next  = cand_reg;
      deb_cnt_next = '0;
      stable_upd   = 1'b1;
    end else begin
      deb_cnt_next = deb_inc;
    end
  end

  always_comb begin
    cls_note = '0;
    for (int i = NUM_NOTES - 1; i >= 0; i--) begin
      if (stable_reg[i]) cls_note = IDX_W'(i);
    end
    cls_rest  = (stable_reg == '0);
    cls_multi = |(stable_reg & (stable_reg - NUM_NOTES'(1)));
  end

  assign dur_inc = (dur_reg == DUR_MAX) ? dur_reg : dur_reg + DUR_W'(1);

  // The finished segment is staged for one cycle before entering the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg      <= '0;
      sync_reg       <= '0;
      cand_reg       <= '0;
      stable_reg     <= '0;
      deb_cnt_reg    <= '0;
      dur_reg        <= '0;
      push_valid_reg <= 1'b0;
      push_data_reg  <= '0;
    end else begin
      sync1_reg      <= note_in;
      sync_reg       <= sync1_reg;
      cand_reg       <= cand_next;
      stable_reg     <= stable_next;
      deb_cnt_reg    <= deb_cnt_next;
      push_valid_reg <= stable_upd;
      if (stable_upd) begin
        push_data_reg <= {cls_note, cls_rest, cls_multi, dur_inc};
        dur_reg       <= '0;
      end else begin
        dur_reg <= dur_inc;
      end
    end
  end

  assign pop     = (count_reg != '0) && evt_ready;
  assign push_ok = push_valid_reg && ((count_reg != DEPTH_C) || pop);
  assign drop    = push_valid_reg && !push_ok;
  assign rd_ptr_next = pop ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;

  always_comb begin
    count_next = count_reg;
    if (push_ok && !pop) count_next = count_reg + CNT_W'(1);
    else if (!push_ok && pop) count_next = count_reg - CNT_W'(1);
  end

  // Head register is loaded from the slot that will be at the front next cycle,
  // bypassing the write when that slot is being filled right now.
  always_comb begin
    if (count_next == '0) head_next = '0;
    else if (push_ok && (wr_ptr_reg == rd_ptr_next)) head_next = push_data_reg;
    else head_next = mem[rd_ptr_next];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      head_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      head_reg   <= head_next;
      if (drop) overflow_reg <= 1'b1;
      else if (clear_ovf) overflow_reg <= 1'b0;
    end
  end

  assign evt_valid  = (count_reg != '0);
  assign fifo_count = count_reg;
  assign overflow   = overflow_reg;
  assign evt_note   = head_reg[EVT_W-1 -: IDX_W];
  assign evt_rest   = head_reg[DUR_W+1];
  assign evt_multi  = head_reg[DUR_W];
  assign evt_dur    = head_reg[DUR_W-1:0];

endmodule
